instr_fetch_unit: RTL and testbench

Fetch stage placed directly upstream of the combinational instruction ROM. It owns the program counter, drives the ROM address each cycle, captures the returned word together with its PC into a small prefetch queue, and presents instructions to the decode stage over a valid/ready handshake. A redirect input (branch, jump, trap, mret) flushes the queue and restarts fetch at a new PC.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 43 ++++
 rtl/instr_fetch_unit.sv | 67 ++++++
 tb/tb_instr_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int          INSTR_W   = 32;
   localparam logic [31:0] PC_STEP   = 32'd4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue holding {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  fetch_entry_t     wr_entry,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_W'(1);
         if (pop)  rptr <= rptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush && !rst) mem[wptr] <= wr_entry;
   end

   assign head = mem[rptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the ROM and feeds decode via valid/ready.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        valid_o,
   input  logic        ready_i
);

   localparam int             CNT_W   = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [31:0]      fetch_pc;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;
   fetch_entry_t     head;
   fetch_entry_t     wr_entry;
   logic             unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

   // A full queue may still accept a word when decode drains the head this cycle.
   assign pop      = valid_o & ready_i;
   assign push     = !redirect_i & ((count < DEPTH_C) | pop);
   assign wr_entry = '{pc: fetch_pc, instr: imem_rdata_i};

   always_ff @(posedge clk_i) begin
      if (rst_i)
         fetch_pc <= RESET_PC;
      else if (redirect_i)
         fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      else if (push)
         fetch_pc <= fetch_pc + PC_STEP;
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .flush    (redirect_i),
      .push     (push),
      .pop      (pop),
      .wr_entry (wr_entry),
      .head     (head),
      .count    (count)
   );

   // Outputs come from registered state only, never from ready/redirect.
   assign imem_addr_o = fetch_pc;
   assign valid_o     = (count != '0);
   assign instr_o     = valid_o ? head.instr : NOP_INSTR;
   assign pc_o        = valid_o ? head.pc    : 32'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised and directed bench for instr_fetch_unit against a queue-based model.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        valid;
   logic        ready;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_fpc;
   logic [31:0] rom_key;
   int          total;
   int          bad;

   instr_fetch_unit #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .imem_addr_o   (imem_addr),
      .imem_rdata_i  (imem_rdata),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .instr_o       (instr),
      .pc_o          (pc),
      .valid_o       (valid),
      .ready_i       (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return a ^ rom_key;
   endfunction

   assign imem_rdata = rom_word(imem_addr);

   function automatic logic        m_valid();  return mq.size() != 0;                endfunction
   function automatic logic [31:0] m_pc();     return (mq.size() != 0) ? mq[0].pc    : 32'h0; endfunction
   function automatic logic [31:0] m_instr();  return (mq.size() != 0) ? mq[0].instr : NOP;   endfunction

   // One clock edge: the model consumes the inputs that were stable across it.
   task automatic tick();
      int  sz;
      bit  do_pop;
      ent_t e;
      @(posedge clk);
      sz     = mq.size();
      do_pop = (sz > 0) && ready;
      if (rst) begin
         mq.delete();
         m_fpc = RESET_PC;
      end else if (redirect) begin
         mq.delete();
         m_fpc = redirect_pc & ~32'h3;
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (sz < DEPTH || do_pop) begin
            e.pc    = m_fpc;
            e.instr = rom_word(m_fpc);
            mq.push_back(e);
            m_fpc = m_fpc + 32'd4;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect = 1'b0; ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (valid !== 1'b0 || instr !== NOP || pc !== 32'h0 || imem_addr !== RESET_PC) begin
         bad++;
         $display("[TB] FAIL reset: got v=%0b ins=%h pc=%h addr=%h want v=0 ins=%h pc=0 addr=%h",
                  valid, instr, pc, imem_addr, NOP, RESET_PC);
      end
   endtask

   task automatic test_stream();
      do_reset();
      rom_key = 32'h0;
      ready   = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         total++;
         if (valid !== 1'b1 || pc !== 32'(4*(n-1)) || instr !== 32'(4*(n-1)) || imem_addr !== 32'(4*n)) begin
            bad++;
            $display("[TB] FAIL stream n=%0d: got v=%0b pc=%h ins=%h addr=%h want v=1 pc=%h ins=%h addr=%h",
                     n, valid, pc, instr, imem_addr, 32'(4*(n-1)), 32'(4*(n-1)), 32'(4*n));
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      rom_key = 32'h0;
      ready   = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         total++;
         if (valid !== 1'b1 || pc !== 32'h0 || imem_addr !== 32'(((k < 4) ? k : 4) * 4)) begin
            bad++;
            $display("[TB] FAIL stall k=%0d: got v=%0b pc=%h addr=%h want v=1 pc=0 addr=%h",
                     k, valid, pc, imem_addr, 32'(((k < 4) ? k : 4) * 4));
         end
      end
      ready = 1'b1;
      for (int j = 0; j <= 4; j++) begin
         total++;
         if (valid !== 1'b1 || pc !== 32'(4*j) || instr !== 32'(4*j)) begin
            bad++;
            $display("[TB] FAIL release j=%0d: got v=%0b pc=%h ins=%h want v=1 pc=%h",
                     j, valid, pc, instr, 32'(4*j));
         end
         tick();
      end
   endtask

   task automatic test_full_one_pop();
      do_reset();
      rom_key = 32'h1234_0000;
      ready   = 1'b0;
      repeat (6) tick();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      for (int r = 0; r < 2; r++) begin
         total++;
         if (valid !== 1'b1 || pc !== 32'h4 || instr !== rom_word(32'h4) || imem_addr !== 32'd20) begin
            bad++;
            $display("[TB] FAIL full_pop r=%0d: got v=%0b pc=%h ins=%h addr=%h want v=1 pc=4 ins=%h addr=14",
                     r, valid, pc, instr, imem_addr, rom_word(32'h4));
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      do_reset();
      rom_key = 32'hCAFE_0000;
      ready   = 1'b0;
      repeat (3) tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      ready       = 1'b1;
      tick();
      total++;
      if (valid !== 1'b0 || pc !== 32'h0 || instr !== NOP || imem_addr !== 32'h100) begin
         bad++;
         $display("[TB] FAIL redirect_flush: got v=%0b pc=%h ins=%h addr=%h want v=0 pc=0 ins=%h addr=100",
                  valid, pc, instr, imem_addr, NOP);
      end
      redirect = 1'b0;
      ready    = 1'b0;
      tick();
      total++;
      if (valid !== 1'b1 || pc !== 32'h100 || instr !== rom_word(32'h100) || imem_addr !== 32'h104) begin
         bad++;
         $display("[TB] FAIL redirect_first: got v=%0b pc=%h ins=%h addr=%h want v=1 pc=100 ins=%h addr=104",
                  valid, pc, instr, imem_addr, rom_word(32'h100));
      end
   endtask

   task automatic test_redirect_reset();
      ready = 1'b1;
      repeat (3) tick();
      rst         = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      tick();
      rst      = 1'b0;
      redirect = 1'b0;
      total++;
      if (imem_addr !== RESET_PC || valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL redirect_reset: got addr=%h v=%0b want addr=%h v=0",
                  imem_addr, valid, RESET_PC);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_seq [3];
      exp_seq[0] = 32'hFFFF_FFFC;
      exp_seq[1] = 32'h0000_0000;
      exp_seq[2] = 32'h0000_0004;
      do_reset();
      rom_key     = $urandom;
      ready       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (valid !== 1'b1 || pc !== exp_seq[i] || instr !== rom_word(exp_seq[i])) begin
            bad++;
            $display("[TB] FAIL wrap i=%0d: got v=%0b pc=%h ins=%h want v=1 pc=%h ins=%h",
                     i, valid, pc, instr, exp_seq[i], rom_word(exp_seq[i]));
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      rom_key = $urandom;
      for (int c = 0; c < 400; c++) begin
         ready       = ($urandom_range(0, 99) < 70);
         redirect    = ($urandom_range(0, 99) < 5);
         redirect_pc = $urandom;
         rst         = ($urandom_range(0, 99) < 1);
         tick();
         total++;
         if (valid !== m_valid() || pc !== m_pc() || instr !== m_instr() || imem_addr !== m_fpc) begin
            bad++;
            $display("[TB] FAIL random c=%0d: got v=%0b pc=%h ins=%h addr=%h want v=%0b pc=%h ins=%h addr=%h",
                     c, valid, pc, instr, imem_addr, m_valid(), m_pc(), m_instr(), m_fpc);
         end
      end
      rst      = 1'b0;
      redirect = 1'b0;
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rom_key     = 32'h0;
      m_fpc       = RESET_PC;
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      ready       = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_full_one_pop();
      test_redirect();
      test_redirect_reset();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
